// File: rtl/spi_xform_slave.sv
// SPI slave that receives a DATA_W-bit word and returns it, optionally
// bit-reversed, in the following frame. Frames alternate RX/TX while ss stays low.
// Ports:
//   clock, resetn      system clock, asynchronous active-low reset
//   sck, ss, mosi      SPI inputs, asynchronous to clock (ss active low)
//   miso, miso_oe      registered slave output and its drive enable
//   rx_data            last completed received word
//   rx_valid           one-clock pulse when rx_data updates
//   frame_err          one-clock pulse when a frame is aborted mid-word
module spi_xform_slave #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned CPOL        = 0,
   parameter int unsigned CPHA        = 0,
   parameter int unsigned REVERSE     = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              sck,
   input  logic              ss,
   input  logic              mosi,
   output logic              miso,
   output logic              miso_oe,
   output logic [DATA_W-1:0] rx_data,
   output logic              rx_valid,
   output logic              frame_err
);

   localparam int unsigned   CNT_W    = $clog2(DATA_W) + 1;
   localparam logic          SCK_IDLE = (CPOL != 0);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, RX, TX} state_t;

   // Synchronizers; vld_pipe marks when the ss chain reflects the pin, not reset values
   logic [SYNC_STAGES-1:0] sck_pipe, ss_pipe, mosi_pipe, vld_pipe;
   logic                   sck_prev;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sck_pipe  <= {SYNC_STAGES{SCK_IDLE}};
         ss_pipe   <= '1;
         mosi_pipe <= '0;
         vld_pipe  <= '0;
         sck_prev  <= SCK_IDLE;
      end else begin
         sck_pipe  <= {sck_pipe[SYNC_STAGES-2:0], sck};
         ss_pipe   <= {ss_pipe[SYNC_STAGES-2:0], ss};
         mosi_pipe <= {mosi_pipe[SYNC_STAGES-2:0], mosi};
         vld_pipe  <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
         sck_prev  <= sck_pipe[SYNC_STAGES-1];
      end
   end

   logic sck_s, ss_s, mosi_s, sync_ok;
   logic sck_rise, sck_fall, lead_edge, trail_edge, sample_edge, shift_edge;

   assign sck_s       = sck_pipe[SYNC_STAGES-1];
   assign ss_s        = ss_pipe[SYNC_STAGES-1];
   assign mosi_s      = mosi_pipe[SYNC_STAGES-1];
   assign sync_ok     = vld_pipe[SYNC_STAGES-1];
   assign sck_rise    = sck_s & ~sck_prev;
   assign sck_fall    = ~sck_s & sck_prev;
   assign lead_edge   = SCK_IDLE ? sck_fall : sck_rise;
   assign trail_edge  = SCK_IDLE ? sck_rise : sck_fall;
   assign sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
   assign shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;

   function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      for (int i = 0; i < DATA_W; i++) r[i] = w[DATA_W-1-i];
      return r;
   endfunction

   state_t              state, state_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [DATA_W-1:0]   rx_shift, rx_shift_nxt, tx_shift, tx_shift_nxt, rx_data_nxt, word;
   logic                rx_valid_nxt, frame_err_nxt, miso_nxt, miso_oe_nxt;
   logic                hold, hold_nxt, armed, armed_nxt;

   assign word = {rx_shift[DATA_W-2:0], mosi_s};

   // State and output registers
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         rx_shift  <= '0;
         tx_shift  <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         miso      <= 1'b1;
         miso_oe   <= 1'b0;
         hold      <= 1'b0;
         armed     <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         rx_shift  <= rx_shift_nxt;
         tx_shift  <= tx_shift_nxt;
         rx_data   <= rx_data_nxt;
         rx_valid  <= rx_valid_nxt;
         frame_err <= frame_err_nxt;
         miso      <= miso_nxt;
         miso_oe   <= miso_oe_nxt;
         hold      <= hold_nxt;
         armed     <= armed_nxt;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      rx_shift_nxt  = rx_shift;
      tx_shift_nxt  = tx_shift;
      rx_data_nxt   = rx_data;
      rx_valid_nxt  = 1'b0;
      frame_err_nxt = 1'b0;
      hold_nxt      = hold;
      // A frame may only start after a genuine ss high has been seen since reset
      armed_nxt     = armed | (sync_ok & ss_s);

      unique case (state)
         IDLE: begin
            cnt_nxt      = '0;
            rx_shift_nxt = '0;
            tx_shift_nxt = '0;
            hold_nxt     = 1'b0;
            if (armed && !ss_s) state_nxt = RX;
         end
         RX, TX: begin
            if (ss_s) begin
               state_nxt     = IDLE;
               cnt_nxt       = '0;
               rx_shift_nxt  = '0;
               tx_shift_nxt  = '0;
               hold_nxt      = 1'b0;
               frame_err_nxt = (cnt != '0);
            end else if (state == RX) begin
               if (sample_edge) begin
                  rx_shift_nxt = word;
                  if (cnt == LAST_BIT) begin
                     rx_data_nxt  = word;
                     rx_valid_nxt = 1'b1;
                     tx_shift_nxt = (REVERSE != 0) ? bit_rev(word) : word;
                     cnt_nxt      = '0;
                     hold_nxt     = 1'b1;
                     state_nxt    = TX;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end
            end else begin
               if (sample_edge) begin
                  if (cnt == LAST_BIT) begin
                     cnt_nxt   = '0;
                     state_nxt = RX;
                  end else begin
                     cnt_nxt = cnt + CNT_W'(1);
                  end
               end else if (shift_edge) begin
                  // The first shift edge after loading only presents the MSB
                  if (hold) hold_nxt = 1'b0;
                  else      tx_shift_nxt = {tx_shift[DATA_W-2:0], 1'b0};
               end
            end
         end
         default: state_nxt = IDLE;
      endcase

      miso_oe_nxt = (state_nxt == TX);
      miso_nxt    = (state_nxt == TX) ? tx_shift_nxt[DATA_W-1] : 1'b1;
   end

endmodule
